// File: rtl/gci_std_display_pkg.sv
// Shared display timing definitions: FSM encoding, default 640x480@60 timing
// and helpers that derive totals and sync-window bounds from porch parameters.
package gci_std_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } dispState_t;

  localparam int unsigned DISP_N_DEF        = 16;
  localparam int unsigned DISP_H_ACTIVE_DEF = 640;
  localparam int unsigned DISP_H_FP_DEF     = 16;
  localparam int unsigned DISP_H_SYNC_DEF   = 96;
  localparam int unsigned DISP_H_BP_DEF     = 48;
  localparam int unsigned DISP_V_ACTIVE_DEF = 480;
  localparam int unsigned DISP_V_FP_DEF     = 10;
  localparam int unsigned DISP_V_SYNC_DEF   = 2;
  localparam int unsigned DISP_V_BP_DEF     = 33;
  localparam logic        DISP_SYNC_POL_DEF = 1'b0;
  localparam int unsigned DISP_CNT_N_DEF    = 11;

  function automatic int unsigned dispTotal(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Sync window is [start, end): it begins right after the front porch.
  function automatic int unsigned dispSyncStart(input int unsigned active, input int unsigned fp);
    return active + fp;
  endfunction

  function automatic int unsigned dispSyncEnd(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync);
    return active + fp + sync;
  endfunction

endpackage

// File: rtl/gci_std_display_sync_counter.sv
// Single-axis display counter: wraps at the axis total and decodes the
// active region, the sync window and the last count from the current value.
module gci_std_display_sync_counter
  import gci_std_display_pkg::*;
#(
  parameter int unsigned P_ACTIVE = DISP_H_ACTIVE_DEF,
  parameter int unsigned P_FP     = DISP_H_FP_DEF,
  parameter int unsigned P_SYNC   = DISP_H_SYNC_DEF,
  parameter int unsigned P_BP     = DISP_H_BP_DEF,
  parameter int unsigned P_CNT_N  = DISP_CNT_N_DEF
)(
  input  logic iCLOCK,
  input  logic iRESET,
  input  logic iCLEAR,
  input  logic iSTEP,
  output logic oLAST,
  output logic oACTIVE,
  output logic oSYNC
);

  localparam int unsigned TOTAL = dispTotal(P_ACTIVE, P_FP, P_SYNC, P_BP);
  localparam logic [P_CNT_N-1:0] LAST_C       = P_CNT_N'(TOTAL - 1);
  localparam logic [P_CNT_N-1:0] ACTIVE_C     = P_CNT_N'(P_ACTIVE);
  localparam logic [P_CNT_N-1:0] SYNC_START_C = P_CNT_N'(dispSyncStart(P_ACTIVE, P_FP));
  localparam logic [P_CNT_N-1:0] SYNC_END_C   = P_CNT_N'(dispSyncEnd(P_ACTIVE, P_FP, P_SYNC));

  logic [P_CNT_N-1:0] count_q;
  logic [P_CNT_N-1:0] count_d;

  // Clear dominates stepping so a stopped timing generator always sits at zero.
  always_comb begin
    count_d = count_q;
    if (iCLEAR) begin
      count_d = '0;
    end else if (iSTEP) begin
      count_d = (count_q == LAST_C) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign oLAST   = (count_q == LAST_C);
  assign oACTIVE = (count_q < ACTIVE_C);
  assign oSYNC   = (count_q >= SYNC_START_C) && (count_q < SYNC_END_C);

endmodule

// File: rtl/gci_std_display_timing_gen.sv
// Display-domain pixel sink: drains the FWFT async FIFO at one word per active
// pixel and drives registered sync/DE/pixel outputs with underflow reporting.
module gci_std_display_timing_gen
  import gci_std_display_pkg::*;
#(
  parameter int unsigned P_N        = DISP_N_DEF,
  parameter int unsigned P_H_ACTIVE = DISP_H_ACTIVE_DEF,
  parameter int unsigned P_H_FP     = DISP_H_FP_DEF,
  parameter int unsigned P_H_SYNC   = DISP_H_SYNC_DEF,
  parameter int unsigned P_H_BP     = DISP_H_BP_DEF,
  parameter int unsigned P_V_ACTIVE = DISP_V_ACTIVE_DEF,
  parameter int unsigned P_V_FP     = DISP_V_FP_DEF,
  parameter int unsigned P_V_SYNC   = DISP_V_SYNC_DEF,
  parameter int unsigned P_V_BP     = DISP_V_BP_DEF,
  parameter logic        P_SYNC_POL = DISP_SYNC_POL_DEF,
  parameter int unsigned P_CNT_N    = DISP_CNT_N_DEF
)(
  input  logic           iCLOCK,
  input  logic           iRESET,
  input  logic           iENA,
  input  logic           iFIFO_EMPTY,
  input  logic [P_N-1:0] iFIFO_DATA,
  output logic           oFIFO_RD_EN,
  input  logic           iUNDERFLOW_CLR,
  output logic           oFRAME_START,
  output logic           oUNDERFLOW,
  output logic           oDISP_HSYNC,
  output logic           oDISP_VSYNC,
  output logic           oDISP_DE,
  output logic [P_N-1:0] oDISP_DATA
);

  dispState_t     state_q;
  logic           frameStart_q;
  logic           underflow_q;
  logic           hsync_q;
  logic           vsync_q;
  logic           de_q;
  logic [P_N-1:0] data_q;

  logic run;
  logic hLast;
  logic vLast;
  logic hActive;
  logic vActive;
  logic hSync;
  logic vSync;
  logic active;
  logic rdEn;
  logic underflowNow;

  assign run          = (state_q == ST_RUN);
  assign active       = hActive && vActive;
  assign rdEn         = run && active && !iFIFO_EMPTY;
  assign underflowNow = run && active && iFIFO_EMPTY;

  gci_std_display_sync_counter #(
    .P_ACTIVE (P_H_ACTIVE),
    .P_FP     (P_H_FP),
    .P_SYNC   (P_H_SYNC),
    .P_BP     (P_H_BP),
    .P_CNT_N  (P_CNT_N)
  ) uHCounter (
    .iCLOCK  (iCLOCK),
    .iRESET  (iRESET),
    .iCLEAR  (!run),
    .iSTEP   (run),
    .oLAST   (hLast),
    .oACTIVE (hActive),
    .oSYNC   (hSync)
  );

  gci_std_display_sync_counter #(
    .P_ACTIVE (P_V_ACTIVE),
    .P_FP     (P_V_FP),
    .P_SYNC   (P_V_SYNC),
    .P_BP     (P_V_BP),
    .P_CNT_N  (P_CNT_N)
  ) uVCounter (
    .iCLOCK  (iCLOCK),
    .iRESET  (iRESET),
    .iCLEAR  (!run),
    .iSTEP   (run && hLast),
    .oLAST   (vLast),
    .oACTIVE (vActive),
    .oSYNC   (vSync)
  );

  // Frame start is registered from the transitions that land on h=0, v=0 in RUN,
  // so it lines up with the first counter cycle of each frame.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state_q      <= ST_IDLE;
      frameStart_q <= 1'b0;
    end else begin
      frameStart_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (iENA) state_q <= ST_PRIME;
        end
        ST_PRIME: begin
          if (!iENA) begin
            state_q <= ST_IDLE;
          end else if (!iFIFO_EMPTY) begin
            state_q      <= ST_RUN;
            frameStart_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (hLast && vLast) begin
            if (!iENA) state_q <= ST_IDLE;
            else       frameStart_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      hsync_q <= ~P_SYNC_POL;
      vsync_q <= ~P_SYNC_POL;
      de_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      hsync_q <= (run && hSync) ? P_SYNC_POL : ~P_SYNC_POL;
      vsync_q <= (run && vSync) ? P_SYNC_POL : ~P_SYNC_POL;
      de_q    <= run && active;
      data_q  <= rdEn ? iFIFO_DATA : '0;
    end
  end

  // A fresh underflow outranks a coincident clear so no event is ever lost.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      underflow_q <= 1'b0;
    end else if (underflowNow) begin
      underflow_q <= 1'b1;
    end else if (iUNDERFLOW_CLR) begin
      underflow_q <= 1'b0;
    end
  end

  assign oFIFO_RD_EN  = rdEn;
  assign oFRAME_START = frameStart_q;
  assign oUNDERFLOW   = underflow_q;
  assign oDISP_HSYNC  = hsync_q;
  assign oDISP_VSYNC  = vsync_q;
  assign oDISP_DE     = de_q;
  assign oDISP_DATA   = data_q;

endmodule

// File: tb/tb_gci_std_display_timing_gen.sv
// Self-checking bench: tiny 8x5 timing, FWFT FIFO model fed with an incrementing
// word sequence, and a cycle-level reference model of the display timing rules.
module tb_gci_std_display_timing_gen;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 2, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2;

  logic       iCLOCK = 1'b0;
  logic       iRESET;
  logic       iENA;
  logic       iFIFO_EMPTY;
  logic [7:0] iFIFO_DATA;
  logic       oFIFO_RD_EN;
  logic       iUNDERFLOW_CLR;
  logic       oFRAME_START;
  logic       oUNDERFLOW;
  logic       oDISP_HSYNC;
  logic       oDISP_VSYNC;
  logic       oDISP_DE;
  logic [7:0] oDISP_DATA;

  gci_std_display_timing_gen #(
    .P_N(8), .P_H_ACTIVE(HA), .P_H_FP(HF), .P_H_SYNC(HS), .P_H_BP(HB),
    .P_V_ACTIVE(VA), .P_V_FP(VF), .P_V_SYNC(VS), .P_V_BP(VB),
    .P_SYNC_POL(1'b0), .P_CNT_N(11)
  ) dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET), .iENA(iENA),
    .iFIFO_EMPTY(iFIFO_EMPTY), .iFIFO_DATA(iFIFO_DATA), .oFIFO_RD_EN(oFIFO_RD_EN),
    .iUNDERFLOW_CLR(iUNDERFLOW_CLR), .oFRAME_START(oFRAME_START), .oUNDERFLOW(oUNDERFLOW),
    .oDISP_HSYNC(oDISP_HSYNC), .oDISP_VSYNC(oDISP_VSYNC), .oDISP_DE(oDISP_DE),
    .oDISP_DATA(oDISP_DATA)
  );

  always #5 iCLOCK = ~iCLOCK;

  int nChecks = 0;
  int nFails  = 0;
  int popCount = 0;

  logic [7:0] fifoQ[$];
  logic [7:0] nextPush = 8'h10;
  bit         forceEmptyR = 1'b0;

  // Reference model: timing position, mode, words consumed, expected registered outputs.
  int         mMode = M_IDLE;
  int         mH = 0;
  int         mV = 0;
  int         mPop = 0;
  bit         eDe = 1'b0, eHs = 1'b1, eVs = 1'b1, eUf = 1'b0;
  logic [7:0] eData = 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("[TB] FAIL %s: got=%0h want=%0h at t=%0t (mode=%0d h=%0d v=%0d)",
               tag, got, want, $time, mMode, mH, mV);
    end
  endtask

  task automatic updateFifoDrive();
    iFIFO_EMPTY = forceEmptyR || (fifoQ.size() == 0);
    iFIFO_DATA  = (fifoQ.size() > 0) ? fifoQ[0] : 8'($urandom);
  endtask

  task automatic pushWords(input int n);
    for (int i = 0; i < n; i++) begin
      fifoQ.push_back(nextPush);
      nextPush = nextPush + 8'd1;
    end
  endtask

  task automatic topUp();
    if (fifoQ.size() < 4) pushWords(4);
  endtask

  task automatic checkResetValues(input string phase);
    checkOutput({phase, "_hsync"}, 32'(oDISP_HSYNC), 32'd1);
    checkOutput({phase, "_vsync"}, 32'(oDISP_VSYNC), 32'd1);
    checkOutput({phase, "_de"}, 32'(oDISP_DE), 32'd0);
    checkOutput({phase, "_data"}, 32'(oDISP_DATA), 32'd0);
    checkOutput({phase, "_underflow"}, 32'(oUNDERFLOW), 32'd0);
    checkOutput({phase, "_frame_start"}, 32'(oFRAME_START), 32'd0);
    checkOutput({phase, "_rd_en"}, 32'(oFIFO_RD_EN), 32'd0);
  endtask

  // One display clock: drive inputs in the low phase, check the pop request,
  // let the edge happen, then compare the registered outputs half a cycle later.
  task automatic applyStimulus(input bit ena, input bit forceEmpty, input bit clr);
    bit run, act, emptyNow, expRd, rdSeen;
    iENA = ena;
    iUNDERFLOW_CLR = clr;
    forceEmptyR = forceEmpty;
    updateFifoDrive();
    emptyNow = iFIFO_EMPTY;
    run   = (mMode == M_RUN);
    act   = run && (mH < HA) && (mV < VA);
    expRd = act && !emptyNow;
    #1;
    rdSeen = oFIFO_RD_EN;
    checkOutput("rd_en", 32'(oFIFO_RD_EN), 32'(expRd));
    checkOutput("frame_start", 32'(oFRAME_START), 32'(run && mH == 0 && mV == 0));
    @(posedge iCLOCK);
    #1;
    if (rdSeen) begin
      popCount++;
      if (fifoQ.size() > 0) void'(fifoQ.pop_front());
    end
    eDe   = act;
    eData = expRd ? 8'(32'h10 + mPop) : 8'h00;
    eHs   = !(run && mH >= HA + HF && mH < HA + HF + HS);
    eVs   = !(run && mV >= VA + VF && mV < VA + VF + VS);
    if (act && emptyNow) eUf = 1'b1;
    else if (clr)        eUf = 1'b0;
    if (expRd) mPop++;
    case (mMode)
      M_IDLE: if (ena) mMode = M_PRIME;
      M_PRIME: begin
        if (!ena) mMode = M_IDLE;
        else if (!emptyNow) begin mMode = M_RUN; mH = 0; mV = 0; end
      end
      default: begin
        if (mH == HT - 1 && mV == VT - 1) begin
          mH = 0; mV = 0;
          if (!ena) mMode = M_IDLE;
        end else if (mH == HT - 1) begin
          mH = 0; mV++;
        end else begin
          mH++;
        end
      end
    endcase
    updateFifoDrive();
    @(negedge iCLOCK);
    #1;
    checkOutput("de", 32'(oDISP_DE), 32'(eDe));
    checkOutput("data", 32'(oDISP_DATA), 32'(eData));
    checkOutput("hsync", 32'(oDISP_HSYNC), 32'(eHs));
    checkOutput("vsync", 32'(oDISP_VSYNC), 32'(eVs));
    checkOutput("underflow", 32'(oUNDERFLOW), 32'(eUf));
  endtask

  // Reset is raised in the clock-low phase and checked before any edge arrives.
  task automatic asyncReset();
    #2;
    iRESET = 1'b1;
    #1;
    checkResetValues("async_rst");
    mMode = M_IDLE; mH = 0; mV = 0;
    eDe = 1'b0; eHs = 1'b1; eVs = 1'b1; eUf = 1'b0; eData = 8'h00;
    @(posedge iCLOCK);
    @(negedge iCLOCK);
    #1;
    checkResetValues("held_rst");
    iENA = 1'b1;
    iRESET = 1'b0;
  endtask

  initial begin
    int popsBefore;
    iRESET = 1'b1;
    iENA = 1'b0;
    iUNDERFLOW_CLR = 1'b0;
    updateFifoDrive();
    repeat (3) @(negedge iCLOCK);
    #1;
    checkResetValues("reset");
    iRESET = 1'b0;

    $display("[TB] idle with display disabled");
    repeat (100) applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] enabled with empty FIFO, then preload");
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
    pushWords(8);
    applyStimulus(1'b1, 1'b0, 1'b0);

    $display("[TB] full frame with FIFO always fed");
    popsBefore = popCount;
    for (int i = 0; i < HT * VT; i++) begin
      topUp();
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
    checkOutput("pops_per_frame", 32'(popCount - popsBefore), 32'(HA * VA));

    $display("[TB] underflow at line 0 pixel 2");
    for (int i = 0; i < HT * VT; i++) begin
      topUp();
      applyStimulus(1'b1, (mMode == M_RUN && mH == 2 && mV == 0), 1'b0);
    end
    checkOutput("uf_sticky", 32'(oUNDERFLOW), 32'd1);
    topUp();
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("uf_cleared", 32'(oUNDERFLOW), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("uf_set_wins", 32'(oUNDERFLOW), 32'd1);

    $display("[TB] display disable mid-frame");
    for (int i = 0; i < 4 * HT * VT && !(mH == 2 && mV == 1); i++) begin
      topUp();
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 2 * HT * VT && mMode != M_IDLE; i++) begin
      topUp();
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    repeat (20) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idle_de", 32'(oDISP_DE), 32'd0);

    $display("[TB] asynchronous reset mid-frame");
    for (int i = 0; i < 4 * HT * VT && !(mMode == M_RUN && mH == 3 && mV == 0); i++) begin
      topUp();
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
    asyncReset();
    repeat (3) begin
      topUp();
      applyStimulus(1'b1, 1'b0, 1'b0);
    end

    $display("[TB] randomized traffic");
    for (int i = 0; i < 800; i++) begin
      bit ena, fe, clr;
      ena = ($urandom_range(0, 99) < 96);
      fe  = ($urandom_range(0, 11) == 0);
      clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) != 0) topUp();
      applyStimulus(ena, fe, clr);
    end

    $display("test done: total=%0d bad=%0d", nChecks, nFails);
    $finish;
  end

endmodule
